// File: rtl/glb_pkg.sv
// Shared types for the global-buffer cluster: word/address types, channel and
// accumulate-state enums, and the bank-select width helper.
package glb_pkg;

   localparam int GLB_DATA_W = 16;
   localparam int GLB_ADDR_W = 10;

   typedef logic [GLB_DATA_W-1:0] data_t;
   typedef logic [GLB_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {IACT = 2'd0, PSUM = 2'd1, WGHT = 2'd2} glb_chan_e;
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} acc_state_e;

   // A single-bank channel still carries a 1-bit (always zero) select.
   function automatic int sel_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

endpackage

// File: rtl/glb_bank.sv
// One buffer bank: synchronous write, registered read-first read port, and a
// second registered read port that feeds the psum accumulate path.
module glb_bank #(
   parameter int DATA_W = 16,
   parameter int ROW_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ROW_W-1:0]  rd_row,
   output logic [DATA_W-1:0] rd_data,
   input  logic              ac_en,
   input  logic [ROW_W-1:0]  ac_row,
   output logic [DATA_W-1:0] ac_data,
   input  logic              wr_en,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [2**ROW_W];

   // NOTE: the array has no reset so it can map onto SRAM/register-file macros.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_row] <= wr_data;
      if (ac_en) ac_data <= mem[ac_row];
   end

   // NOTE: non-blocking assignments make this read sample the pre-write word (read-first).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_row];
   end

endmodule

// File: rtl/glb_cluster_banked.sv
// Banked global buffer with iact/psum/wght channels. Define GLB_PSUM_ACC_EN to
// enable the psum read-modify-write accumulate FSM, write stall and forwarding.
module glb_cluster_banked
   import glb_pkg::*;
#(
   parameter int DATA_BITWIDTH  = GLB_DATA_W,
   parameter int ADDR_BITWIDTH  = GLB_ADDR_W,
   parameter int NUM_BANKS_IACT = 2,
   parameter int NUM_BANKS_PSUM = 2,
   parameter int NUM_BANKS_WGHT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     read_req_iact,
   input  logic [ADDR_BITWIDTH-1:0] r_addr_iact,
   output logic                     r_valid_iact,
   output logic [DATA_BITWIDTH-1:0] r_data_iact,
   input  logic                     write_en_iact,
   input  logic [ADDR_BITWIDTH-1:0] w_addr_iact,
   input  logic [DATA_BITWIDTH-1:0] w_data_iact,
   output logic                     w_ready_iact,
   input  logic                     read_req_psum,
   input  logic [ADDR_BITWIDTH-1:0] r_addr_psum,
   output logic                     r_valid_psum,
   output logic [DATA_BITWIDTH-1:0] r_data_psum,
   input  logic                     write_en_psum,
   input  logic [ADDR_BITWIDTH-1:0] w_addr_psum,
   input  logic [DATA_BITWIDTH-1:0] w_data_psum,
   input  logic                     w_acc_psum,
   output logic                     w_ready_psum,
   input  logic                     read_req_wght,
   input  logic [ADDR_BITWIDTH-1:0] r_addr_wght,
   output logic                     r_valid_wght,
   output logic [DATA_BITWIDTH-1:0] r_data_wght,
   input  logic                     write_en_wght,
   input  logic [ADDR_BITWIDTH-1:0] w_addr_wght,
   input  logic [DATA_BITWIDTH-1:0] w_data_wght,
   output logic                     w_ready_wght
);

   localparam int IACT_SW = sel_w(NUM_BANKS_IACT);
   localparam int PSUM_SW = sel_w(NUM_BANKS_PSUM);
   localparam int WGHT_SW = sel_w(NUM_BANKS_WGHT);
   localparam int IACT_RW = ADDR_BITWIDTH - $clog2(NUM_BANKS_IACT);
   localparam int PSUM_RW = ADDR_BITWIDTH - $clog2(NUM_BANKS_PSUM);
   localparam int WGHT_RW = ADDR_BITWIDTH - $clog2(NUM_BANKS_WGHT);

   logic [IACT_SW-1:0]       iact_rsel, iact_wsel, iact_sel_q;
   logic [PSUM_SW-1:0]       psum_rsel, psum_wsel_in, psum_wsel, psum_sel_q;
   logic [WGHT_SW-1:0]       wght_rsel, wght_wsel, wght_sel_q;
   logic [DATA_BITWIDTH-1:0] iact_rd [NUM_BANKS_IACT];
   logic [DATA_BITWIDTH-1:0] psum_rd [NUM_BANKS_PSUM];
   logic [DATA_BITWIDTH-1:0] wght_rd [NUM_BANKS_WGHT];
   logic [DATA_BITWIDTH-1:0] psum_ac [NUM_BANKS_PSUM];
   logic [DATA_BITWIDTH-1:0] unused_iact_ac [NUM_BANKS_IACT];
   logic [DATA_BITWIDTH-1:0] unused_wght_ac [NUM_BANKS_WGHT];
   logic [PSUM_RW-1:0]       psum_wrow;
   logic [DATA_BITWIDTH-1:0] psum_wdata, psum_mux;
   logic                     psum_wgo, psum_acgo;

   // Bank index is the top address bits; a shift past the width yields bank 0.
   assign iact_rsel    = IACT_SW'(r_addr_iact >> IACT_RW);
   assign iact_wsel    = IACT_SW'(w_addr_iact >> IACT_RW);
   assign psum_rsel    = PSUM_SW'(r_addr_psum >> PSUM_RW);
   assign psum_wsel_in = PSUM_SW'(w_addr_psum >> PSUM_RW);
   assign wght_rsel    = WGHT_SW'(r_addr_wght >> WGHT_RW);
   assign wght_wsel    = WGHT_SW'(w_addr_wght >> WGHT_RW);
   assign w_ready_iact = 1'b1;
   assign w_ready_wght = 1'b1;

   for (genvar b = 0; b < NUM_BANKS_IACT; b++) begin : g_iact
      glb_bank #(.DATA_W(DATA_BITWIDTH), .ROW_W(IACT_RW)) u_bank (
         .clk     (clk),
         .reset   (reset),
         .rd_en   (read_req_iact && (iact_rsel == IACT_SW'(b))),
         .rd_row  (r_addr_iact[IACT_RW-1:0]),
         .rd_data (iact_rd[b]),
         .ac_en   (1'b0),
         .ac_row  ('0),
         .ac_data (unused_iact_ac[b]),
         .wr_en   (write_en_iact && (iact_wsel == IACT_SW'(b))),
         .wr_row  (w_addr_iact[IACT_RW-1:0]),
         .wr_data (w_data_iact)
      );
   end

   for (genvar b = 0; b < NUM_BANKS_PSUM; b++) begin : g_psum
      glb_bank #(.DATA_W(DATA_BITWIDTH), .ROW_W(PSUM_RW)) u_bank (
         .clk     (clk),
         .reset   (reset),
         .rd_en   (read_req_psum && (psum_rsel == PSUM_SW'(b))),
         .rd_row  (r_addr_psum[PSUM_RW-1:0]),
         .rd_data (psum_rd[b]),
         .ac_en   (psum_acgo && (psum_wsel_in == PSUM_SW'(b))),
         .ac_row  (w_addr_psum[PSUM_RW-1:0]),
         .ac_data (psum_ac[b]),
         .wr_en   (psum_wgo && (psum_wsel == PSUM_SW'(b))),
         .wr_row  (psum_wrow),
         .wr_data (psum_wdata)
      );
   end

   for (genvar b = 0; b < NUM_BANKS_WGHT; b++) begin : g_wght
      glb_bank #(.DATA_W(DATA_BITWIDTH), .ROW_W(WGHT_RW)) u_bank (
         .clk     (clk),
         .reset   (reset),
         .rd_en   (read_req_wght && (wght_rsel == WGHT_SW'(b))),
         .rd_row  (r_addr_wght[WGHT_RW-1:0]),
         .rd_data (wght_rd[b]),
         .ac_en   (1'b0),
         .ac_row  ('0),
         .ac_data (unused_wght_ac[b]),
         .wr_en   (write_en_wght && (wght_wsel == WGHT_SW'(b))),
         .wr_row  (w_addr_wght[WGHT_RW-1:0]),
         .wr_data (w_data_wght)
      );
   end

   // Bank select is registered with the read so r_data stays on the last bank read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid_iact <= 1'b0;
         r_valid_psum <= 1'b0;
         r_valid_wght <= 1'b0;
         iact_sel_q   <= '0;
         psum_sel_q   <= '0;
         wght_sel_q   <= '0;
      end else begin
         r_valid_iact <= read_req_iact;
         r_valid_psum <= read_req_psum;
         r_valid_wght <= read_req_wght;
         if (read_req_iact) iact_sel_q <= iact_rsel;
         if (read_req_psum) psum_sel_q <= psum_rsel;
         if (read_req_wght) wght_sel_q <= wght_rsel;
      end
   end

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      r_data_iact = '0;
      psum_mux    = '0;
      r_data_wght = '0;
      for (int b = 0; b < NUM_BANKS_IACT; b++)
         if (iact_sel_q == IACT_SW'(b)) r_data_iact = iact_rd[b];
      for (int b = 0; b < NUM_BANKS_PSUM; b++)
         if (psum_sel_q == PSUM_SW'(b)) psum_mux = psum_rd[b];
      for (int b = 0; b < NUM_BANKS_WGHT; b++)
         if (wght_sel_q == WGHT_SW'(b)) r_data_wght = wght_rd[b];
   end

`ifdef GLB_PSUM_ACC_EN
   acc_state_e               state_q;
   logic [ADDR_BITWIDTH-1:0] acc_addr_q;
   logic [DATA_BITWIDTH-1:0] acc_data_q, acc_rd, acc_sum, fwd_data_q;
   logic [PSUM_SW-1:0]       acc_sel;
   logic                     fwd_q, acc_go, plain_go, in_acc;

   assign in_acc       = (state_q == ACC);
   assign w_ready_psum = !in_acc;
   assign acc_go       = write_en_psum && w_acc_psum && w_ready_psum;
   assign plain_go     = write_en_psum && !w_acc_psum && w_ready_psum;
   assign acc_sel      = PSUM_SW'(acc_addr_q >> PSUM_RW);

   always_comb begin
      acc_rd = '0;
      for (int b = 0; b < NUM_BANKS_PSUM; b++)
         if (acc_sel == PSUM_SW'(b)) acc_rd = psum_ac[b];
   end

   assign acc_sum     = acc_rd + acc_data_q;
   assign psum_acgo   = acc_go;
   assign psum_wgo    = plain_go || in_acc;
   assign psum_wsel   = in_acc ? acc_sel : psum_wsel_in;
   assign psum_wrow   = in_acc ? acc_addr_q[PSUM_RW-1:0] : w_addr_psum[PSUM_RW-1:0];
   assign psum_wdata  = in_acc ? acc_sum : w_data_psum;
   assign r_data_psum = fwd_q ? fwd_data_q : psum_mux;

   // A read of the latched address during ACC sees the sum being committed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         acc_addr_q <= '0;
         acc_data_q <= '0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         if (in_acc) begin
            state_q <= IDLE;
         end else if (acc_go) begin
            state_q    <= ACC;
            acc_addr_q <= w_addr_psum;
            acc_data_q <= w_data_psum;
         end
         if (read_req_psum) begin
            fwd_q      <= in_acc && (r_addr_psum == acc_addr_q);
            fwd_data_q <= acc_sum;
         end
      end
   end

   // A write offered while stalled is dropped; the controller must never do that.
   a_no_write_when_stalled : assert property (@(posedge clk) disable iff (!reset)
      !(write_en_psum && !w_ready_psum));
`else
   logic unused_psum;

   assign w_ready_psum = 1'b1;
   assign psum_acgo    = 1'b0;
   assign psum_wgo     = write_en_psum;
   assign psum_wsel    = psum_wsel_in;
   assign psum_wrow    = w_addr_psum[PSUM_RW-1:0];
   assign psum_wdata   = w_data_psum;
   assign r_data_psum  = psum_mux;

   always_comb begin
      unused_psum = w_acc_psum;
      for (int b = 0; b < NUM_BANKS_PSUM; b++) unused_psum = unused_psum ^ (^psum_ac[b]);
   end
`endif

endmodule

// File: tb/tb_glb_cluster_banked.sv
// Scoreboard bench for glb_cluster_banked: reads push expected words, a negedge
// monitor pops and compares whenever r_valid is presented.
module tb_glb_cluster_banked;
   import glb_pkg::*;

`ifdef GLB_PSUM_ACC_EN
   localparam bit ACC_ON = 1'b1;
`else
   localparam bit ACC_ON = 1'b0;
`endif

   typedef struct {
      data_t data;
      int    cyc;
   } exp_t;

   logic  clk   = 1'b0;
   logic  reset = 1'b0;
   logic  read_req_iact, write_en_iact, r_valid_iact, w_ready_iact;
   logic  read_req_psum, write_en_psum, r_valid_psum, w_ready_psum, w_acc_psum;
   logic  read_req_wght, write_en_wght, r_valid_wght, w_ready_wght;
   addr_t r_addr_iact, w_addr_iact, r_addr_psum, w_addr_psum, r_addr_wght, w_addr_wght;
   data_t r_data_iact, w_data_iact, r_data_psum, w_data_psum, r_data_wght, w_data_wght;

   exp_t q_iact[$];
   exp_t q_psum[$];
   exp_t q_wght[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   glb_cluster_banked dut (
      .clk           (clk),
      .reset         (reset),
      .read_req_iact (read_req_iact),
      .r_addr_iact   (r_addr_iact),
      .r_valid_iact  (r_valid_iact),
      .r_data_iact   (r_data_iact),
      .write_en_iact (write_en_iact),
      .w_addr_iact   (w_addr_iact),
      .w_data_iact   (w_data_iact),
      .w_ready_iact  (w_ready_iact),
      .read_req_psum (read_req_psum),
      .r_addr_psum   (r_addr_psum),
      .r_valid_psum  (r_valid_psum),
      .r_data_psum   (r_data_psum),
      .write_en_psum (write_en_psum),
      .w_addr_psum   (w_addr_psum),
      .w_data_psum   (w_data_psum),
      .w_acc_psum    (w_acc_psum),
      .w_ready_psum  (w_ready_psum),
      .read_req_wght (read_req_wght),
      .r_addr_wght   (r_addr_wght),
      .r_valid_wght  (r_valid_wght),
      .r_data_wght   (r_data_wght),
      .write_en_wght (write_en_wght),
      .w_addr_wght   (w_addr_wght),
      .w_data_wght   (w_data_wght),
      .w_ready_wght  (w_ready_wght)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clear_inputs();
      read_req_iact = 1'b0; write_en_iact = 1'b0;
      read_req_psum = 1'b0; write_en_psum = 1'b0; w_acc_psum = 1'b0;
      read_req_wght = 1'b0; write_en_wght = 1'b0;
      r_addr_iact = '0; w_addr_iact = '0; w_data_iact = '0;
      r_addr_psum = '0; w_addr_psum = '0; w_data_psum = '0;
      r_addr_wght = '0; w_addr_wght = '0; w_data_wght = '0;
   endtask

   // Inputs are set just after a negedge; step() lets one posedge consume them.
   task automatic step();
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic set_wr(input glb_chan_e ch, input addr_t a, input data_t d, input logic acc);
      case (ch)
         IACT:    begin write_en_iact = 1'b1; w_addr_iact = a; w_data_iact = d; end
         PSUM:    begin write_en_psum = 1'b1; w_addr_psum = a; w_data_psum = d; w_acc_psum = acc; end
         default: begin write_en_wght = 1'b1; w_addr_wght = a; w_data_wght = d; end
      endcase
   endtask

   task automatic set_rd(input glb_chan_e ch, input addr_t a, input data_t exp);
      exp_t e;
      e.data = exp;
      e.cyc  = cyc + 1;
      case (ch)
         IACT:    begin read_req_iact = 1'b1; r_addr_iact = a; q_iact.push_back(e); end
         PSUM:    begin read_req_psum = 1'b1; r_addr_psum = a; q_psum.push_back(e); end
         default: begin read_req_wght = 1'b1; r_addr_wght = a; q_wght.push_back(e); end
      endcase
   endtask

   task automatic mon(input glb_chan_e ch, input logic v, input data_t d);
      exp_t  e;
      bit    have = 1'b0;
      string nm   = ch.name();
      case (ch)
         IACT:    if (q_iact.size() > 0 && q_iact[0].cyc <= cyc) begin e = q_iact.pop_front(); have = 1'b1; end
         PSUM:    if (q_psum.size() > 0 && q_psum[0].cyc <= cyc) begin e = q_psum.pop_front(); have = 1'b1; end
         default: if (q_wght.size() > 0 && q_wght[0].cyc <= cyc) begin e = q_wght.pop_front(); have = 1'b1; end
      endcase
      if (have) begin
         check({nm, "_r_valid"}, 32'(v), 32'd1);
         check({nm, "_r_data"}, 32'(d), 32'(e.data));
      end else if (v) begin
         check({nm, "_spurious_r_valid"}, 32'(v), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         mon(IACT, r_valid_iact, r_data_iact);
         mon(PSUM, r_valid_psum, r_data_psum);
         mon(WGHT, r_valid_wght, r_data_wght);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_r_valid_iact", 32'(r_valid_iact), 32'd0);
      check("reset_r_valid_psum", 32'(r_valid_psum), 32'd0);
      check("reset_r_valid_wght", 32'(r_valid_wght), 32'd0);
      check("reset_r_data_iact", 32'(r_data_iact), 32'd0);
      check("reset_r_data_psum", 32'(r_data_psum), 32'd0);
      check("reset_r_data_wght", 32'(r_data_wght), 32'd0);
      check("reset_w_ready_psum", 32'(w_ready_psum), 32'd1);
      step();

      // Bank spread on iact: 0x000 lands in bank 0, 0x200 in bank 1.
      set_wr(IACT, 10'h000, 16'h1111, 1'b0); step();
      set_wr(IACT, 10'h200, 16'h2222, 1'b0); step();
      set_rd(IACT, 10'h000, 16'h1111); step();
      set_rd(IACT, 10'h200, 16'h2222); step();
      step(); step();
      check("iact_r_data_held", 32'(r_data_iact), 32'h2222);
      check("iact_r_valid_dropped", 32'(r_valid_iact), 32'd0);

      // Single-bank wght: the full address is the row.
      set_wr(WGHT, 10'h3FF, 16'h5A5A, 1'b0); step();
      set_wr(WGHT, 10'h001, 16'hC3C3, 1'b0); step();
      set_rd(WGHT, 10'h3FF, 16'h5A5A); step();
      set_rd(WGHT, 10'h001, 16'hC3C3); step();
      step();

      // Same-address read and write: read returns the old word.
      set_wr(IACT, 10'h005, 16'hAAAA, 1'b0); step();
      set_rd(IACT, 10'h005, 16'hAAAA); set_wr(IACT, 10'h005, 16'hBBBB, 1'b0); step();
      set_rd(IACT, 10'h005, 16'hBBBB); step();
      step();

      // Accumulate 3 + 4 at psum 0x10, with an unrelated bank-1 word at 0x210.
      set_wr(PSUM, 10'h210, 16'h1234, 1'b0); step();
      set_wr(PSUM, 10'h010, 16'h0003, 1'b0); set_rd(PSUM, 10'h210, 16'h1234); step();
      check("psum_w_ready_idle", 32'(w_ready_psum), 32'd1);
      set_wr(PSUM, 10'h010, 16'h0004, 1'b1); set_rd(PSUM, 10'h010, 16'h0003); step();
      check("psum_w_ready_in_acc", 32'(w_ready_psum), ACC_ON ? 32'd0 : 32'd1);
      set_rd(PSUM, 10'h010, ACC_ON ? 16'h0007 : 16'h0004); step();
      check("psum_w_ready_after_acc", 32'(w_ready_psum), 32'd1);
      set_rd(PSUM, 10'h010, ACC_ON ? 16'h0007 : 16'h0004); step();
      step();

      // Wrap: 0xFFFF + 2 = 0x0001.
      set_wr(PSUM, 10'h020, 16'hFFFF, 1'b0); step();
      set_wr(PSUM, 10'h020, 16'h0002, 1'b1); step();
      step();
      set_rd(PSUM, 10'h020, ACC_ON ? 16'h0001 : 16'h0002); step();
      step();

      // Reset during ACC: the pending sum must not be written.
      set_wr(PSUM, 10'h010, 16'h0004, 1'b1); step();
      check("psum_w_ready_before_reset", 32'(w_ready_psum), ACC_ON ? 32'd0 : 32'd1);
      reset = 1'b0;
      #1;
      check("psum_w_ready_in_reset", 32'(w_ready_psum), 32'd1);
      check("psum_r_valid_in_reset", 32'(r_valid_psum), 32'd0);
      check("psum_r_data_in_reset", 32'(r_data_psum), 32'd0);
      step();
      reset = 1'b1;
      set_rd(PSUM, 10'h010, ACC_ON ? 16'h0007 : 16'h0004); step();
      step(); step();

      check("iact_scoreboard_drained", 32'(q_iact.size()), 32'd0);
      check("psum_scoreboard_drained", 32'(q_psum.size()), 32'd0);
      check("wght_scoreboard_drained", 32'(q_wght.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
